// File: rtl/stack_pkg.sv
// Shared stack-processor definitions: data-stack opcode encodings and default stack geometry.
package stack_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_PUSH = 3'b001;
  localparam logic [2:0] OP_POP  = 3'b010;
  localparam logic [2:0] OP_REPL = 3'b011;
  localparam logic [2:0] OP_BIN  = 3'b100;
  localparam logic [2:0] OP_DUP  = 3'b101;
  localparam logic [2:0] OP_SWAP = 3'b110;
  localparam logic [2:0] OP_OVER = 3'b111;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 16;

endpackage

// File: rtl/data_stack_if.sv
// Control/datapath-facing bundle of the data stack; overflow/underflow exist only with DATA_STACK_ERR_EN.
interface data_stack_if
  import stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic [2:0]       stackOP;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] next;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
`ifdef DATA_STACK_ERR_EN
  logic             overflow;
  logic             underflow;
`endif

  modport master (
    output stackOP, din,
    input  top, next, count, full, empty
`ifdef DATA_STACK_ERR_EN
    , input overflow, underflow
`endif
  );

  modport slave (
    input  stackOP, din,
    output top, next, count, full, empty
`ifdef DATA_STACK_ERR_EN
    , output overflow, underflow
`endif
  );

endinterface

// File: rtl/stack_regfile.sv
// DEPTH x WIDTH stack storage: two asynchronous read ports, two synchronous write ports.
module stack_regfile #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [AW-1:0]    ra0,
  input  logic [AW-1:0]    ra1,
  output logic [WIDTH-1:0] rd0,
  output logic [WIDTH-1:0] rd1,
  input  logic             we0,
  input  logic [AW-1:0]    wa0,
  input  logic [WIDTH-1:0] wd0,
  input  logic             we1,
  input  logic [AW-1:0]    wa1,
  input  logic [WIDTH-1:0] wd1
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];

  // Port 1 only ever targets a different entry from port 0 (SWAP), so order is irrelevant.
  always_ff @(posedge clk) begin
    if (we0) mem[wa0] <= wd0;
    if (we1) mem[wa1] <= wd1;
  end

endmodule

// File: rtl/data_stack.sv
// Data-stack execution unit: one stack op per clock, TOS/NOS operands, illegal ops suppressed.
// Optional sticky overflow/underflow flags are built when DATA_STACK_ERR_EN is defined.
module data_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic         CLK,
  input logic         reset,
  data_stack_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]    sp, sp_nxt;
  logic [AW-1:0]    ptr, ptr_m1, ptr_m2;
  logic [AW-1:0]    wa0, wa1;
  logic [WIDTH-1:0] wd0, wd1;
  logic [WIDTH-1:0] tos_raw, nos_raw;
  logic             we0, we1;
  logic             tos_ok, nos_ok, is_full;
  logic             ovf_ev, unf_ev;

  assign ptr     = sp[AW-1:0];
  assign ptr_m1  = ptr - AW'(1);
  assign ptr_m2  = ptr - AW'(2);
  assign is_full = (sp == CW'(DEPTH));
  assign tos_ok  = (sp != '0);
  assign nos_ok  = (sp > CW'(1));

  stack_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk (CLK),
    .ra0 (ptr_m1),
    .ra1 (ptr_m2),
    .rd0 (tos_raw),
    .rd1 (nos_raw),
    .we0 (we0 & ~reset),
    .wa0 (wa0),
    .wd0 (wd0),
    .we1 (we1 & ~reset),
    .wa1 (wa1),
    .wd1 (wd1)
  );

  // Legality check: underflow is tested before full so it wins for DUP/OVER.
  always_comb begin
    sp_nxt = sp;
    we0    = 1'b0;
    wa0    = ptr;
    wd0    = bus.din;
    we1    = 1'b0;
    wa1    = ptr_m2;
    wd1    = tos_raw;
    ovf_ev = 1'b0;
    unf_ev = 1'b0;
    case (bus.stackOP)
      OP_NOP: ;
      OP_PUSH: begin
        if (is_full) ovf_ev = 1'b1;
        else begin
          we0    = 1'b1;
          sp_nxt = sp + 1'b1;
        end
      end
      OP_POP: begin
        if (!tos_ok) unf_ev = 1'b1;
        else sp_nxt = sp - 1'b1;
      end
      OP_REPL: begin
        if (!tos_ok) unf_ev = 1'b1;
        else begin
          we0 = 1'b1;
          wa0 = ptr_m1;
        end
      end
      OP_BIN: begin
        if (!nos_ok) unf_ev = 1'b1;
        else begin
          we0    = 1'b1;
          wa0    = ptr_m2;
          sp_nxt = sp - 1'b1;
        end
      end
      OP_DUP: begin
        if (!tos_ok) unf_ev = 1'b1;
        else if (is_full) ovf_ev = 1'b1;
        else begin
          we0    = 1'b1;
          wd0    = tos_raw;
          sp_nxt = sp + 1'b1;
        end
      end
      OP_SWAP: begin
        if (!nos_ok) unf_ev = 1'b1;
        else begin
          we0 = 1'b1;
          wa0 = ptr_m1;
          wd0 = nos_raw;
          we1 = 1'b1;
        end
      end
      OP_OVER: begin
        if (!nos_ok) unf_ev = 1'b1;
        else if (is_full) ovf_ev = 1'b1;
        else begin
          we0    = 1'b1;
          wd0    = nos_raw;
          sp_nxt = sp + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) sp <= '0;
    else       sp <= sp_nxt;
  end

  assign bus.top   = tos_ok ? tos_raw : '0;
  assign bus.next  = nos_ok ? nos_raw : '0;
  assign bus.count = sp;
  assign bus.full  = is_full;
  assign bus.empty = ~tos_ok;

`ifdef DATA_STACK_ERR_EN
  logic ovf_q, unf_q;

  always_ff @(posedge CLK) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ovf_ev) ovf_q <= 1'b1;
      if (unf_ev) unf_q <= 1'b1;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`else
  logic unused_ev;
  assign unused_ev = ovf_ev | unf_ev;
`endif

endmodule

// File: tb/tb_data_stack.sv
// Scoreboard bench for data_stack: stimulus queues hand-computed post-edge state, a monitor checks it.
module tb_data_stack;
  import stack_pkg::*;

  localparam int W = 16;
  localparam int D = 16;

  typedef struct {
    logic [W-1:0] top;
    logic [W-1:0] nxt;
    logic [4:0]   cnt;
    logic         full;
    logic         empty;
    logic         ovf;
    logic         unf;
  } exp_t;

  logic clk;
  logic reset;
  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  data_stack_if #(.WIDTH(W), .DEPTH(D)) bus ();

  data_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: state is stable 1 time unit after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("top",   32'(bus.top),   32'(e.top));
      chk("next",  32'(bus.next),  32'(e.nxt));
      chk("count", 32'(bus.count), 32'(e.cnt));
      chk("full",  32'(bus.full),  32'(e.full));
      chk("empty", 32'(bus.empty), 32'(e.empty));
`ifdef DATA_STACK_ERR_EN
      chk("overflow",  32'(bus.overflow),  32'(e.ovf));
      chk("underflow", 32'(bus.underflow), 32'(e.unf));
`endif
    end
  end

  task automatic step(input logic r, input logic [2:0] op, input logic [W-1:0] d,
                      input logic [W-1:0] et, input logic [W-1:0] en, input int ec,
                      input logic eo, input logic eu);
    exp_t e;
    @(negedge clk);
    reset       = r;
    bus.stackOP = op;
    bus.din     = d;
    e.top   = et;
    e.nxt   = en;
    e.cnt   = 5'(ec);
    e.full  = (ec == D);
    e.empty = (ec == 0);
    e.ovf   = eo;
    e.unf   = eu;
    q.push_back(e);
  endtask

  initial begin
    reset       = 1'b1;
    bus.stackOP = OP_NOP;
    bus.din     = '0;

    // Reset, PUSH/PUSH, SWAP
    step(1, OP_NOP,  16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    step(0, OP_PUSH, 16'h0011, 16'h0011, 16'h0000, 1, 0, 0);
    step(0, OP_PUSH, 16'h0022, 16'h0022, 16'h0011, 2, 0, 0);
    step(0, OP_SWAP, 16'h0000, 16'h0011, 16'h0022, 2, 0, 0);

    // BIN then REPL
    step(1, OP_NOP,  16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    step(0, OP_PUSH, 16'h0005, 16'h0005, 16'h0000, 1, 0, 0);
    step(0, OP_PUSH, 16'h0003, 16'h0003, 16'h0005, 2, 0, 0);
    step(0, OP_BIN,  16'h0008, 16'h0008, 16'h0000, 1, 0, 0);
    step(0, OP_REPL, 16'hFFFF, 16'hFFFF, 16'h0000, 1, 0, 0);

    // DUP, OVER, POP to empty, then underflowing POP
    step(1, OP_NOP,  16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    step(0, OP_PUSH, 16'h0007, 16'h0007, 16'h0000, 1, 0, 0);
    step(0, OP_DUP,  16'h0000, 16'h0007, 16'h0007, 2, 0, 0);
    step(0, OP_OVER, 16'h0000, 16'h0007, 16'h0007, 3, 0, 0);
    step(0, OP_POP,  16'h0000, 16'h0007, 16'h0007, 2, 0, 0);
    step(0, OP_POP,  16'h0000, 16'h0007, 16'h0000, 1, 0, 0);
    step(0, OP_POP,  16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    step(0, OP_POP,  16'h0000, 16'h0000, 16'h0000, 0, 0, 1);

    // Fill to DEPTH, then overflowing PUSH/DUP/OVER, then POP
    step(1, OP_NOP,  16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    for (int i = 0; i < D; i++)
      step(0, OP_PUSH, 16'(16'h0100 + i), 16'(16'h0100 + i),
           (i == 0) ? 16'h0000 : 16'(16'h0100 + i - 1), i + 1, 0, 0);
    step(0, OP_PUSH, 16'hDEAD, 16'h010F, 16'h010E, 16, 1, 0);
    step(0, OP_DUP,  16'h0000, 16'h010F, 16'h010E, 16, 1, 0);
    step(0, OP_OVER, 16'h0000, 16'h010F, 16'h010E, 16, 1, 0);
    step(0, OP_POP,  16'h0000, 16'h010E, 16'h010D, 15, 1, 0);

    // Count 1: SWAP and BIN suppressed, then reset together with PUSH
    step(1, OP_NOP,  16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    step(0, OP_PUSH, 16'hAAAA, 16'hAAAA, 16'h0000, 1, 0, 0);
    step(0, OP_SWAP, 16'h0000, 16'hAAAA, 16'h0000, 1, 0, 1);
    step(0, OP_BIN,  16'h5555, 16'hAAAA, 16'h0000, 1, 0, 1);
    step(1, OP_PUSH, 16'h1234, 16'h0000, 16'h0000, 0, 0, 0);
    step(0, OP_REPL, 16'h4321, 16'h0000, 16'h0000, 0, 0, 1);
    step(1, OP_NOP,  16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    step(0, OP_PUSH, 16'h0009, 16'h0009, 16'h0000, 1, 0, 0);
    step(0, OP_OVER, 16'h0000, 16'h0009, 16'h0000, 1, 0, 1);
    step(0, OP_PUSH, 16'h000A, 16'h000A, 16'h0009, 2, 0, 1);
    step(0, OP_NOP,  16'hBEEF, 16'h000A, 16'h0009, 2, 0, 1);

    @(negedge clk);
    bus.stackOP = OP_NOP;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
